// File: rtl/tdes_pkg.sv
// tdes_pkg: shared state, pass and mode encodings for the Triple-DES sequencer.
package tdes_pkg;

    typedef enum logic [2:0] {IDLE, START, WAIT, OUT, ERR} state_t;

    localparam logic [1:0] PASS0 = 2'd0;
    localparam logic [1:0] PASS1 = 2'd1;
    localparam logic [1:0] PASS2 = 2'd2;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/tdes_pass_select.sv
// tdes_pass_select: picks the core key and mode for each EDE pass.
module tdes_pass_select
    import tdes_pkg::*;
(
    input  logic [1:0]  pass,
    input  logic        decrypt,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic [63:0] des_key,
    output logic        des_decrypt
);

    // Decrypt walks the key list backwards, so the outer passes swap key1/key3.
    assign des_key     = pass == PASS1 ? key2 : ((pass == PASS0) != decrypt) ? key1 : key3;
    assign des_decrypt = (pass == PASS1) ? (decrypt ? MODE_ENC : MODE_DEC) : (decrypt ? MODE_DEC : MODE_ENC);

endmodule

// File: rtl/tdes_sequencer.sv
// tdes_sequencer: runs one shared DES core three times (EDE, 3-key) per 64-bit block.
module tdes_sequencer
    import tdes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_decrypt,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        err,
    output logic        des_reset,
    output logic [63:0] des_din,
    output logic [63:0] des_key,
    output logic        des_decrypt,
    input  logic [63:0] des_dout,
    input  logic        des_done
);

    state_t           state, state_n;
    logic [1:0]       pass, pass_n;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      work, work_n, k1, k2, k3, k1_n, k2_n, k3_n, sel_key;
    logic             dec, dec_n, sel_dec, accept, done, timeout;

    assign accept  = state == IDLE && in_valid && in_ready;
    assign done    = state == WAIT && des_done;
    assign timeout = state == WAIT && !des_done && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign work_n  = accept ? in_data : done ? des_dout : work;
    assign k1_n    = accept ? key1 : k1;
    assign k2_n    = accept ? key2 : k2;
    assign k3_n    = accept ? key3 : k3;
    assign dec_n   = accept ? in_decrypt : dec;

    always_comb begin
        state_n = state;
        pass_n  = pass;
        case (state)
            IDLE:  if (accept) begin
                state_n = START;
                pass_n  = PASS0;
            end
            START: state_n = WAIT;
            WAIT:  if (done) begin
                state_n = pass == PASS2 ? OUT : START;
                pass_n  = pass == PASS2 ? pass : pass + 2'd1;
            end else if (timeout) begin
                state_n = ERR;
            end
            OUT:   if (out_ready) state_n = IDLE;
            default: ;
        endcase
    end

    // Selection runs on next-state values so the core inputs are valid during START.
    tdes_pass_select u_pass_select (
        .pass        (pass_n),
        .decrypt     (dec_n),
        .key1        (k1_n),
        .key2        (k2_n),
        .key3        (k3_n),
        .des_key     (sel_key),
        .des_decrypt (sel_dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pass        <= PASS0;
            cnt         <= '0;
            work        <= '0;
            k1          <= '0;
            k2          <= '0;
            k3          <= '0;
            dec         <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err         <= 1'b0;
            des_reset   <= 1'b1;
            des_din     <= '0;
            des_key     <= '0;
            des_decrypt <= 1'b0;
        end else begin
            state     <= state_n;
            pass      <= pass_n;
            work      <= work_n;
            k1        <= k1_n;
            k2        <= k2_n;
            k3        <= k3_n;
            dec       <= dec_n;
            cnt       <= (state == WAIT && !des_done && !timeout) ? cnt + 1'b1 : '0;
            in_ready  <= state_n == IDLE;
            out_valid <= state_n == OUT;
            des_reset <= state_n != WAIT;
            err       <= err || timeout;
            if (state_n == START) begin
                des_din     <= work_n;
                des_key     <= sel_key;
                des_decrypt <= sel_dec;
            end
            if (done && pass == PASS2) out_data <= des_dout;
        end
    end

endmodule

// File: tb/tb_tdes_sequencer.sv
// tb_tdes_sequencer: randomized checks of the Triple-DES sequencer against an EDE reference,
// using a stand-in core with an invertible toy cipher and programmable latency.
module tb_tdes_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_decrypt = 1'b0;
    logic [63:0] key1 = '0, key2 = '0, key3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        err;
    logic        des_reset;
    logic [63:0] des_din, des_key, des_dout;
    logic        des_decrypt, des_done;

    int checks = 0;
    int failures = 0;
    int lat = 0;
    bit stall = 1'b0;
    int core_cnt;
    logic rst_q;
    logic [63:0] key_log[$];
    logic        mode_log[$];

    tdes_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_decrypt(in_decrypt), .key1(key1), .key2(key2), .key3(key3),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err),
        .des_reset(des_reset), .des_din(des_din), .des_key(des_key), .des_decrypt(des_decrypt),
        .des_dout(des_dout), .des_done(des_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fenc(input logic [63:0] d, input logic [63:0] k);
        logic [63:0] t;
        t = d ^ k;
        return {t[58:0], t[63:59]} + k;
    endfunction

    function automatic logic [63:0] fdec(input logic [63:0] c, input logic [63:0] k);
        logic [63:0] t;
        t = c - k;
        return {t[4:0], t[63:5]} ^ k;
    endfunction

    // EDE: encrypt = E(k3, D(k2, E(k1, x))); decrypt is the exact inverse.
    function automatic logic [63:0] tdes_model(input logic [63:0] x, input logic dec,
                                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        return dec ? fdec(fenc(fdec(x, c), b), a) : fenc(fdec(fenc(x, a), b), c);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Stand-in core: restarts while des_reset is high, answers after lat idle cycles.
    always @(posedge clk) begin
        if (des_reset) begin
            core_cnt <= 0;
            des_done <= 1'b0;
            des_dout <= '0;
        end else if (!stall && core_cnt >= lat) begin
            des_done <= 1'b1;
            des_dout <= des_decrypt ? fdec(des_din, des_key) : fenc(des_din, des_key);
        end else begin
            core_cnt <= core_cnt + 1;
        end
    end

    // Record key/mode at the start of each pass (first cycle with des_reset low).
    always @(posedge clk) begin
        rst_q <= des_reset;
        if (rst_q && !des_reset) begin
            key_log.push_back(des_key);
            mode_log.push_back(des_decrypt);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_txn(input logic [63:0] x, input logic dec, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c, input int hold,
                           output logic [63:0] res);
        int n, base;
        logic [63:0] exp_res, held;
        logic [191:0] exp_keys, got_keys;
        logic [2:0] exp_modes, got_modes;
        exp_res   = tdes_model(x, dec, a, b, c);
        exp_keys  = dec ? {c, b, a} : {a, b, c};
        exp_modes = dec ? 3'b101 : 3'b010;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        base = key_log.size();
        in_data = x; in_decrypt = dec; key1 = a; key2 = b; key3 = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = rnd64(); in_decrypt = ~dec; key1 = rnd64(); key2 = rnd64(); key3 = rnd64();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL accept_drop: in_ready=%b required 0", in_ready);
        end
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
        res = out_data;
        checks++;
        if (res !== exp_res) begin
            failures++;
            $display("FAIL result: out_data=%h required %h", res, exp_res);
        end
        checks++;
        if (key_log.size() - base != 3) begin
            failures++;
            $display("FAIL pass_count: passes=%0d required 3", key_log.size() - base);
        end else begin
            got_keys  = {key_log[base], key_log[base+1], key_log[base+2]};
            got_modes = {mode_log[base], mode_log[base+1], mode_log[base+2]};
            if (got_keys !== exp_keys || got_modes !== exp_modes) begin
                failures++;
                $display("FAIL key_order: keys=%h modes=%b required %h %b",
                         got_keys, got_modes, exp_keys, exp_modes);
            end
        end
        if (hold > 0) begin
            held = out_data;
            in_valid = 1'b1;
            in_data = rnd64();
            repeat (hold) begin
                @(negedge clk);
                checks++;
                if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0
                    || key_log.size() - base != 3) begin
                    failures++;
                    $display("FAIL backpressure: out_data=%h out_valid=%b in_ready=%b passes=%0d required %h 1 0 3",
                             out_data, out_valid, in_ready, key_log.size() - base, held);
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL release: out_valid=%b in_ready=%b err=%b required 0 1 0",
                     out_valid, in_ready, err);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, err, des_reset, des_decrypt} !== 5'b00010
            || out_data !== '0 || des_din !== '0 || des_key !== '0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b ov=%b err=%b dr=%b dd=%b od=%h din=%h key=%h required 0 0 0 1 0 zeros",
                     in_ready, out_valid, err, des_reset, des_decrypt, out_data, des_din, des_key);
        end
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_same_keys();
        logic [63:0] k, x, r;
        k = rnd64(); x = rnd64(); lat = 2;
        run_txn(x, 1'b0, k, k, k, 0, r);
        checks++;
        if (r !== fenc(x, k)) begin
            failures++;
            $display("FAIL single_equiv: out=%h required %h", r, fenc(x, k));
        end
        run_txn(r, 1'b1, k, k, k, 0, r);
    endtask

    task automatic test_roundtrip();
        logic [63:0] a, b, c, x, y, z;
        for (int i = 0; i < 4; i++) begin
            a = rnd64(); b = rnd64(); c = rnd64(); x = rnd64();
            lat = int'($urandom_range(0, 6));
            run_txn(x, 1'b0, a, b, c, 0, y);
            lat = int'($urandom_range(0, 6));
            run_txn(y, 1'b1, a, b, c, 0, z);
            checks++;
            if (z !== x) begin
                failures++;
                $display("FAIL roundtrip: out=%h required %h", z, x);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        for (int i = 0; i < 6; i++) begin
            lat = int'($urandom_range(0, 10));
            run_txn(rnd64(), 1'($urandom_range(0, 1)), rnd64(), rnd64(), rnd64(), 0, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        lat = 1;
        run_txn(rnd64(), 1'b0, rnd64(), rnd64(), rnd64(), 20, r);
        run_txn(rnd64(), 1'b1, rnd64(), rnd64(), rnd64(), 3, r);
    endtask

    task automatic test_reset_mid();
        int n, base;
        logic [63:0] r;
        lat = 5;
        base = key_log.size();
        in_data = rnd64(); key1 = rnd64(); key2 = rnd64(); key3 = rnd64(); in_decrypt = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (key_log.size() - base < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, err, des_reset} !== 4'b0001 || out_data !== '0) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b ov=%b err=%b dr=%b od=%h required 0 0 0 1 0",
                     in_ready, out_valid, err, des_reset, out_data);
        end
        reset = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL stale_out: out_valid cycles=%0d required 0", n);
        end
        lat = 3;
        run_txn(rnd64(), 1'b1, rnd64(), rnd64(), rnd64(), 0, r);
    endtask

    task automatic test_timeout();
        int n;
        stall = 1'b1;
        in_data = rnd64(); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL early_err: err=%b required 0", err);
        end
        n = 0;
        while (!err && n < 150) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err: err=%b required 1", err);
        end
        stall = 1'b0;
        in_valid = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready || out_valid || !err || !des_reset) n++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL err_hold: bad cycles=%0d required 0", n);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_clear: err=%b in_ready=%b required 0 1", err, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_same_keys();
        test_roundtrip();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdes_sequencer.md
Name: tdes_sequencer

Overview:
- Controller that runs one shared DES_Encrypt core three times to perform Triple-DES (EDE, 3-key).
- Accepts one 64-bit block per transaction over a valid/ready handshake and sequences the core's key, mode and data for each pass.
- Restarts the core per pass, captures each intermediate result, and returns the final block over a valid/ready output handshake.
- Sits between the system-side data path and a single DES_Encrypt instance.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles to wait for des_done per pass before flagging an error.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  input block valid.
- in_ready  out  1  sequencer can accept a block.
- in_data  in  64  plaintext or ciphertext block.
- in_decrypt  in  1  0 = 3DES encrypt, 1 = 3DES decrypt.
- key1, key2, key3  in  64 each  3DES keys; sampled on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  64  3DES result.
- err  out  1  sticky; set on core timeout.
- des_reset  out  1  active-high restart to core (core's own polarity).
- des_din  out  64  core dataIn.
- des_key  out  64  core key.
- des_decrypt  out  1  core decrypt select.
- des_dout  in  64  core dataOut.
- des_done  in  1  core result valid.

Behaviour:
- Reset (reset=0 at clk edge), outputs: in_ready=0, out_valid=0, out_data=0, err=0, des_reset=1, des_din=0, des_key=0, des_decrypt=0. State=IDLE, pass=0, timeout counter=0.
- Reset mid-operation aborts the transaction; no partial result is emitted.
- States: IDLE, START, WAIT, OUT, ERR.
- IDLE: in_ready=1, des_reset=1.
  - Accept when in_valid && in_ready: latch in_data into working register, latch in_decrypt and all three keys, set pass=0, go to START.
  - in_ready drops the cycle after accept.
- START (1 cycle): des_reset=1; drive des_din=working register and the key/mode for the current pass. Go to WAIT.
- Pass schedule:
  - Encrypt: pass0 = E with key1, pass1 = D with key2, pass2 = E with key3.
  - Decrypt: pass0 = D with key3, pass1 = E with key2, pass2 = D with key1.
- WAIT:
  - des_reset=0; des_din, des_key and des_decrypt are held stable; the timeout counter increments each cycle.
  - On des_done=1:
    - Capture des_dout into the working register and clear the counter.
    - If pass<2: pass+1, go to START.
    - Otherwise: load out_data, go to OUT.
  - des_done is ignored in every state except WAIT.
- Timeout: if the counter reaches TIMEOUT_CYCLES with des_done=0, set err=1 and go to ERR.
- ERR: in_ready=0, out_valid=0, des_reset=1. Held until reset; err is cleared only by reset.
- OUT:
  - out_valid=1 and out_data is held stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - out_valid drops the next cycle; in_ready rises the same cycle.
  - No new block is accepted in the cycle out_ready is seen, because one transaction is in flight at most.
- Latency: accept→out_valid = 3*(2 + Lcore) cycles, where Lcore is the count of des_done-wait cycles per pass.
- Key or in_data changes after accept have no effect on the transaction in flight.

Decomposition:
- Shared package tdes_pkg holds:
  - State encoding localparams: IDLE, START, WAIT, OUT, ERR.
  - Pass index constants: 0, 1, 2.
  - Mode constants: MODE_ENC=0, MODE_DEC=1.
- Pass key/mode selection is a natural sub-module: tdes_pass_select (combinational: pass, in_decrypt, key1..key3 → des_key, des_decrypt).
- FSM, counters and registers stay in tdes_sequencer.

Test Plan:
- Common setup: instantiate with a real DES_Encrypt core; hold reset=0 for 2 cycles, then release.
- Encrypt, k1=k2=k3=64'hAABB09182736CCDD, in_data=64'h123456ABCD132536 → out_data=64'hC0B7A8D05F3A829C; err=0; des_reset pulses exactly 3 times.
- Decrypt with the same keys, in_data=64'hC0B7A8D05F3A829C → out_data=64'h123456ABCD132536.
- Three distinct keys:
  - Encrypt block X, then feed the result back with in_decrypt=1 → output equals X.
  - Check des_key order: key1, key2, key3 for encrypt; key3, key2, key1 for decrypt.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_data stable, in_ready=0, no second accept. Release → out_valid drops next cycle.
- Timeout: replace the core with a stub that never asserts des_done → err=1 after TIMEOUT_CYCLES in WAIT; in_ready stays 0 until reset.
- Reset mid-pass: assert reset=0 during pass1 WAIT → next cycle state IDLE-reset values. Then a fresh transaction completes correctly and no stale out_valid appears.
